// File: rtl/stopwatch_cmd_arbiter.sv
// Stopwatch command arbiter: grants one of two requesters (front panel, host),
// checks the command against the stopwatch status, issues a one-cycle control
// pulse, waits for status confirmation with a bounded timeout, then acks.
module stopwatch_cmd_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pnl_req,
    input  logic [1:0] pnl_cmd,
    input  logic       host_req,
    input  logic [1:0] host_cmd,
    input  logic [1:0] sw_status,
    output logic       sw_start,
    output logic       sw_stop,
    output logic       sw_reset,
    output logic       pnl_ack,
    output logic       host_ack,
    output logic       nak,
    output logic       timeout_err,
    output logic       busy
);

    localparam logic [1:0] CmdNop   = 2'b00;
    localparam logic [1:0] CmdStart = 2'b01;
    localparam logic [1:0] CmdStop  = 2'b10;
    localparam logic [1:0] CmdReset = 2'b11;

    localparam logic [1:0] StatIdle    = 2'b00;
    localparam logic [1:0] StatRunning = 2'b01;
    localparam logic [1:0] StatPaused  = 2'b10;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e     state_q;
    logic [1:0] cmd_q;
    logic       src_host_q;   // latched source: 1 = host, 0 = panel
    logic       prio_host_q;  // round-robin pointer: 1 = host wins next contention
    logic [7:0] cnt_q;

    logic       pnl_is_rst;
    logic       host_is_rst;
    logic       grant_valid;
    logic       grant_host;
    logic [1:0] grant_cmd;
    logic       grant_legal;
    logic [1:0] expect_status;

    // Arbitration, legality of the candidate grant and expected confirmation status
    always_comb begin
        pnl_is_rst  = pnl_req && (pnl_cmd == CmdReset);
        host_is_rst = host_req && (host_cmd == CmdReset);
        grant_valid = pnl_req | host_req;
        if (pnl_req && host_req) begin
            // A lone RESET beats round-robin
            if (pnl_is_rst != host_is_rst) begin
                grant_host = host_is_rst;
            end else begin
                grant_host = prio_host_q;
            end
        end else begin
            grant_host = host_req;
        end
        grant_cmd = grant_host ? host_cmd : pnl_cmd;
        case (grant_cmd)
            CmdStart: grant_legal = (sw_status == StatIdle) || (sw_status == StatPaused);
            CmdStop:  grant_legal = (sw_status == StatRunning);
            default:  grant_legal = 1'b1;
        endcase
        case (cmd_q)
            CmdStart: expect_status = StatRunning;
            CmdStop:  expect_status = StatPaused;
            default:  expect_status = StatIdle;
        endcase
    end

    // Control FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_q       <= CmdNop;
            src_host_q  <= 1'b0;
            prio_host_q <= 1'b0;
            cnt_q       <= 8'd0;
            sw_start    <= 1'b0;
            sw_stop     <= 1'b0;
            sw_reset    <= 1'b0;
            pnl_ack     <= 1'b0;
            host_ack    <= 1'b0;
            nak         <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sw_start <= 1'b0;
            sw_stop  <= 1'b0;
            sw_reset <= 1'b0;
            pnl_ack  <= 1'b0;
            host_ack <= 1'b0;
            nak      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        cmd_q       <= grant_cmd;
                        src_host_q  <= grant_host;
                        prio_host_q <= ~grant_host;
                        busy        <= 1'b1;
                        if ((grant_cmd == CmdNop) || !grant_legal) begin
                            state_q  <= StResp;
                            pnl_ack  <= ~grant_host;
                            host_ack <= grant_host;
                            nak      <= ~grant_legal;
                        end else begin
                            state_q  <= StIssue;
                            sw_start <= (grant_cmd == CmdStart);
                            sw_stop  <= (grant_cmd == CmdStop);
                            sw_reset <= (grant_cmd == CmdReset);
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    cnt_q   <= 8'd0;
                end
                StWait: begin
                    if (sw_status == expect_status) begin
                        state_q  <= StResp;
                        pnl_ack  <= ~src_host_q;
                        host_ack <= src_host_q;
                    end else if (cnt_q == CntLast) begin
                        state_q     <= StResp;
                        pnl_ack     <= ~src_host_q;
                        host_ack    <= src_host_q;
                        nak         <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
